twf_seq_gen: RTL and testbench
==============================

Name: twf_seq_gen

Overview:
- Parametrised twiddle-factor sequencer for the N-point radix-2 DIF FFT pipeline.
- Holds a quarter-wave cosine table of N/4+1 entries and derives all N twiddles by quadrant folding.
- On a start pulse for a given stage, streams LANES twiddles per beat under valid/ready flow control.
- Supports a conjugate (inverse-FFT) mode; replaces fixed per-stage full tables.

Parameters:
- N, 64, FFT size; power of 2, at least 8.
- W, 9, signed twiddle width; unity = 2^(W-2).
- LANES, 8, twiddles per beat; power of 2, at most N/2.
- LOG2N, $clog2(N), stage index range.
- BEATS, N/(2*LANES), beats per stage.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request a stage sequence; 1-cycle pulse
- stage  in  $clog2(LOG2N)  stage index, 0..LOG2N-1
- inverse  in  1  1 = conjugate twiddles (IFFT)
- busy  out  1  sequence in progress
- err  out  1  1-cycle pulse when start carries stage >= LOG2N
- tw_valid  out  1  output beat valid
- tw_ready  in  1  consumer accepts beat
- tw_re  out  LANES*W  lane i at bits [i*W +: W], signed
- tw_im  out  LANES*W  same packing
- tw_beat  out  $clog2(BEATS)+1  index of presented beat
- tw_last  out  1  presented beat is the final beat of the stage

Behaviour:
- Reset (rst high at a clk edge): state IDLE. busy, err, tw_valid, tw_last, tw_beat, tw_re, tw_im all 0. Reset overrides everything, including mid-sequence; the partial sequence is discarded.
- Table: C[m] = round(2^(W-2)*cos(2*pi*m/N)), m = 0..N/4. Rounding is half away from zero. Values are elaboration-time constants.
- Exponent, lane i of beat k: b = k*LANES + i; e = (b mod (N >> (s+1))) << s, where s is the latched stage.
- Folding: q = e / (N/4), m = e mod (N/4).
  - q0: re = C[m], im = -C[N/4-m]
  - q1: re = -C[N/4-m], im = -C[m]
  - q2: re = -C[m], im = C[N/4-m]
  - q3: re = C[N/4-m], im = C[m]
- inverse latched high: im is negated. All values fit W bits signed; no saturation needed.
- State IDLE:
  - start with stage < LOG2N: latch stage and inverse, load output registers with beat 0, set tw_valid=1 and busy=1 from the next cycle, go to RUN. Latency start -> first tw_valid is 1 cycle.
  - start with stage >= LOG2N: err=1 for one cycle; stay IDLE.
- State RUN:
  - Outputs hold stable while tw_valid && !tw_ready.
  - Handshake on a non-last beat: load the next beat the following cycle; no bubbles, so full throughput is 1 beat/cycle.
  - Handshake on the last beat (tw_beat = BEATS-1, tw_last=1): next cycle tw_valid=0, busy=0, state IDLE.
  - If start is also high in that cycle with a legal stage, it is accepted as if in IDLE: the next cycle presents beat 0 of the new stage with no gap, and busy stays 1.
- start while RUN (other than the last-beat handshake cycle): ignored, no err, latched stage/inverse unchanged.
- tw_ready while tw_valid=0: ignored.
- Output data is fully registered; no combinational path from tw_ready to tw_re/tw_im.

Test Plan:
- Reset, then start stage=0 inverse=0, tw_ready=1 (defaults):
  - tw_valid rises 1 cycle later.
  - Beat 0: lane0 (128,0), lane1 (127,-13).
  - Beat 2: lane0 (0,-128).
  - Beat 3: lane7 (-127,-13) with tw_last=1.
  - Exactly 4 beats, then busy=0.
- start stage=1: beat 0 lane1 = (126,-25); beat 2 lane0 = (128,0) since e wraps.
- start stage=5: all 32 twiddles = (128,0).
- start stage=0 inverse=1: beat 0 lane1 = (127,13); beat 2 lane0 = (0,128).
- Backpressure:
  - tw_ready toggled randomly: each beat is presented stable until accepted, and no beat is lost or duplicated.
  - start pulsed mid-RUN: ignored.
  - start on the last-beat handshake: beat 0 follows immediately with no gap.
- start stage=6: err pulses 1 cycle, tw_valid stays 0. rst asserted during beat 1: all outputs 0 the next cycle and state IDLE.

Source files
------------

// File: rtl/twf_seq_if.sv
// Twiddle output stream: registered lane-packed re/im beats under valid/ready.
// The sequencer drives through the master modport; the FFT datapath consumes via slave.
interface twf_seq_if #(
    parameter int LANES = 8,
    parameter int W     = 9,
    parameter int BW    = 3
);
    logic               tw_valid;
    logic               tw_ready;
    logic [LANES*W-1:0] tw_re;
    logic [LANES*W-1:0] tw_im;
    logic [BW-1:0]      tw_beat;
    logic               tw_last;

    modport master (
        output tw_valid,
        output tw_re,
        output tw_im,
        output tw_beat,
        output tw_last,
        input  tw_ready
    );

    modport slave (
        input  tw_valid,
        input  tw_re,
        input  tw_im,
        input  tw_beat,
        input  tw_last,
        output tw_ready
    );
endinterface

// File: rtl/twf_seq_gen.sv
// Twiddle-factor sequencer for a radix-2 DIF FFT: quarter-wave cosine table,
// quadrant folding, LANES twiddles per beat for the requested stage.
//
// state | meaning
// IDLE  | no sequence; waiting for a legal start
// RUN   | presenting beats of the latched stage until the last one is taken
module twf_seq_gen #(
    parameter int N     = 64,
    parameter int W     = 9,
    parameter int LANES = 8,
    parameter int LOG2N = $clog2(N),
    parameter int BEATS = N / (2 * LANES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [$clog2(LOG2N)-1:0] stage,
    input  logic                     inverse,
    output logic                     busy,
    output logic                     err,
    twf_seq_if.master                tw
);
    localparam int SW = $clog2(LOG2N);
    localparam int BW = $clog2(BEATS) + 1;
    localparam int Q  = N / 4;
    localparam int MW = LOG2N - 1;

    function automatic logic [(Q+1)*W-1:0] build_cos();
        logic [(Q+1)*W-1:0] t;
        real x;
        int  v;
        t = '0;
        for (int m = 0; m <= Q; m++) begin
            x = real'(2 ** (W - 2)) * $cos(2.0 * 3.14159265358979323846 * real'(m) / real'(N));
            v = (x >= 0.0) ? int'($floor(x + 0.5)) : -int'($floor(0.5 - x));
            t[m*W +: W] = v[W-1:0];
        end
        return t;
    endfunction

    localparam logic [(Q+1)*W-1:0] COS_TBL = build_cos();

    // Returns {re, im} for one lane of the given beat.
    function automatic logic [2*W-1:0] twiddle(
        input logic [BW-1:0] bt,
        input logic [SW-1:0] s,
        input logic          inv,
        input int            lane
    );
        logic [LOG2N-1:0]     b;
        logic [LOG2N-1:0]     mask;
        logic [LOG2N-1:0]     e;
        logic [1:0]           q;
        logic [MW-1:0]        m;
        logic [MW-1:0]        mc;
        logic signed [W-1:0]  cm;
        logic signed [W-1:0]  cc;
        logic signed [W-1:0]  re;
        logic signed [W-1:0]  im;
        b    = LOG2N'(bt) * LOG2N'(LANES) + LOG2N'(lane);
        mask = LOG2N'((N >> (s + 1)) - 1);
        e    = (b & mask) << s;
        q    = e[LOG2N-1 -: 2];
        m    = MW'(e[LOG2N-3:0]);
        mc   = MW'(Q) - m;
        cm   = COS_TBL[m*W +: W];
        cc   = COS_TBL[mc*W +: W];
        case (q)
            2'd0:    begin re = cm;  im = -cc; end
            2'd1:    begin re = -cc; im = -cm; end
            2'd2:    begin re = -cm; im = cc;  end
            default: begin re = cc;  im = cm;  end
        endcase
        if (inv) im = -im;
        return {re, im};
    endfunction

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_n;
    logic [SW-1:0]      stage_q, load_stage;
    logic               inv_q, load_inv;
    logic [BW-1:0]      load_beat;
    logic               load, valid_n, err_n, legal;
    logic [LANES*W-1:0] nxt_re, nxt_im;

    assign legal = start && (int'(stage) < LOG2N);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        load       = 1'b0;
        load_beat  = tw.tw_beat + 1'b1;
        load_stage = stage_q;
        load_inv   = inv_q;
        valid_n    = tw.tw_valid;
        err_n      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (legal) begin
                        load       = 1'b1;
                        load_beat  = '0;
                        load_stage = stage;
                        load_inv   = inverse;
                        valid_n    = 1'b1;
                        state_n    = RUN;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (tw.tw_valid && tw.tw_ready) begin
                    if (!tw.tw_last) begin
                        load = 1'b1;
                    end else if (legal) begin
                        // chained start on the final handshake: no gap between stages
                        load       = 1'b1;
                        load_beat  = '0;
                        load_stage = stage;
                        load_inv   = inverse;
                    end else begin
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        nxt_re = '0;
        nxt_im = '0;
        for (int i = 0; i < LANES; i++) begin
            {nxt_re[i*W +: W], nxt_im[i*W +: W]} = twiddle(load_beat, load_stage, load_inv, i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q     <= '0;
            inv_q       <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            tw.tw_valid <= 1'b0;
            tw.tw_last  <= 1'b0;
            tw.tw_beat  <= '0;
            tw.tw_re    <= '0;
            tw.tw_im    <= '0;
        end else begin
            busy        <= (state_n == RUN);
            err         <= err_n;
            tw.tw_valid <= valid_n;
            if (load) begin
                stage_q    <= load_stage;
                inv_q      <= load_inv;
                tw.tw_beat <= load_beat;
                tw.tw_last <= (load_beat == BW'(BEATS - 1));
                tw.tw_re   <= nxt_re;
                tw.tw_im   <= nxt_im;
            end else if (!valid_n) begin
                tw.tw_last <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_twf_seq_gen.sv
// Scoreboard bench for twf_seq_gen: stimulus queues expected beats (trig model
// plus hand-computed spot values), a negedge monitor pops and compares on handshakes.
module tb_twf_seq_gen;
    localparam int N     = 64;
    localparam int W     = 9;
    localparam int LANES = 8;
    localparam int LOG2N = 6;
    localparam int BEATS = 4;
    localparam int SW    = 3;
    localparam int BW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] stage = '0;
    logic          inverse = 1'b0;
    logic          busy, err;

    twf_seq_if #(.LANES(LANES), .W(W), .BW(BW)) tw ();

    twf_seq_gen #(.N(N), .W(W), .LANES(LANES)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stage   (stage),
        .inverse (inverse),
        .busy    (busy),
        .err     (err),
        .tw      (tw.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0]      beat;
        logic               last;
        logic [LANES*W-1:0] re;
        logic [LANES*W-1:0] im;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? int'($floor(x + 0.5)) : -int'($floor(0.5 - x));
    endfunction

    // Independent model: direct full-circle cos/sin, no table folding.
    task automatic push_stage(input int s, input bit inv);
        exp_t t;
        int   b, e, re, im;
        real  ang;
        for (int k = 0; k < BEATS; k++) begin
            t.beat = BW'(k);
            t.last = (k == BEATS - 1);
            t.re   = '0;
            t.im   = '0;
            for (int i = 0; i < LANES; i++) begin
                b   = k * LANES + i;
                e   = (b % (N >> (s + 1))) << s;
                ang = 2.0 * 3.14159265358979323846 * real'(e) / real'(N);
                re  = rnd(128.0 * $cos(ang));
                im  = rnd(-128.0 * $sin(ang));
                if (inv) im = -im;
                t.re[i*W +: W] = re[W-1:0];
                t.im[i*W +: W] = im[W-1:0];
            end
            exp_q.push_back(t);
        end
    endtask

    task automatic set_lane(input int idx, input int lane, input int re, input int im);
        exp_t t;
        t = exp_q[idx];
        t.re[lane*W +: W] = re[W-1:0];
        t.im[lane*W +: W] = im[W-1:0];
        exp_q[idx] = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check({name, "_drain_left"}, exp_q.size(), 0);
        check({name, "_valid_after"}, int'(tw.tw_valid), 0);
        check({name, "_busy_after"}, int'(busy), 0);
    endtask

    // Monitor: handshake compare plus stability of stalled beats.
    logic               stall = 1'b0;
    logic [BW-1:0]      h_beat;
    logic [LANES*W-1:0] h_re, h_im;

    always @(negedge clk) begin
        exp_t               e;
        logic signed [W-1:0] a, r;
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall)
                check("hold_stable", int'(tw.tw_valid && tw.tw_beat == h_beat &&
                      tw.tw_re == h_re && tw.tw_im == h_im), 1);
            if (tw.tw_valid && tw.tw_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=beat%0d required=none", tw.tw_beat);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_idx", int'(tw.tw_beat), int'(e.beat));
                    check($sformatf("last_b%0d", e.beat), int'(tw.tw_last), int'(e.last));
                    for (int i = 0; i < LANES; i++) begin
                        a = tw.tw_re[i*W +: W];
                        r = e.re[i*W +: W];
                        check($sformatf("re_b%0d_l%0d", e.beat, i), int'(a), int'(r));
                        a = tw.tw_im[i*W +: W];
                        r = e.im[i*W +: W];
                        check($sformatf("im_b%0d_l%0d", e.beat, i), int'(a), int'(r));
                    end
                end
            end
            stall  = tw.tw_valid && !tw.tw_ready;
            h_beat = tw.tw_beat;
            h_re   = tw.tw_re;
            h_im   = tw.tw_im;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int base, n, cyc;
        tw.tw_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy",  int'(busy), 0);
        check("rst_err",   int'(err), 0);
        check("rst_valid", int'(tw.tw_valid), 0);
        check("rst_last",  int'(tw.tw_last), 0);
        check("rst_beat",  int'(tw.tw_beat), 0);
        check("rst_data",  int'(tw.tw_re != '0 || tw.tw_im != '0), 0);
        rst = 1'b0;
        tw.tw_ready = 1'b1;
        tick();

        // stage 0 forward
        base = exp_q.size();
        push_stage(0, 1'b0);
        set_lane(base + 0, 0, 128, 0);
        set_lane(base + 0, 1, 127, -13);
        set_lane(base + 2, 0, 0, -128);
        set_lane(base + 3, 7, -127, -13);
        start = 1'b1; stage = 3'd0; inverse = 1'b0;
        check("s0_valid_before", int'(tw.tw_valid), 0);
        tick();
        start = 1'b0;
        check("s0_latency_valid", int'(tw.tw_valid), 1);
        check("s0_busy", int'(busy), 1);
        drain("s0");

        // stage 1
        base = exp_q.size();
        push_stage(1, 1'b0);
        set_lane(base + 0, 1, 126, -25);
        set_lane(base + 2, 0, 128, 0);
        start = 1'b1; stage = 3'd1;
        tick();
        start = 1'b0;
        drain("s1");

        // stage 5: all unity
        base = exp_q.size();
        push_stage(5, 1'b0);
        for (int k = 0; k < BEATS; k++)
            for (int i = 0; i < LANES; i++) set_lane(base + k, i, 128, 0);
        start = 1'b1; stage = 3'd5;
        tick();
        start = 1'b0;
        drain("s5");

        // stage 0 inverse
        base = exp_q.size();
        push_stage(0, 1'b1);
        set_lane(base + 0, 1, 127, 13);
        set_lane(base + 2, 0, 0, 128);
        start = 1'b1; stage = 3'd0; inverse = 1'b1;
        tick();
        start = 1'b0; inverse = 1'b0;
        drain("s0inv");

        // random backpressure, with an ignored start while stalled
        push_stage(2, 1'b0);
        start = 1'b1; stage = 3'd2;
        tick();
        start = 1'b0;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            if (cyc == 3) begin
                tw.tw_ready = 1'b0;
                start = 1'b1; stage = 3'd5; inverse = 1'b1;
            end else begin
                tw.tw_ready = 1'($urandom_range(0, 1));
            end
            tick();
            start = 1'b0; inverse = 1'b0;
            if (cyc == 3) begin
                check("midrun_no_err", int'(err), 0);
                check("midrun_busy", int'(busy), 1);
            end
            cyc++;
        end
        check("bp_drain_left", exp_q.size(), 0);
        tw.tw_ready = 1'b1;
        repeat (3) tick();
        check("bp_valid_after", int'(tw.tw_valid), 0);
        check("bp_busy_after", int'(busy), 0);

        // chained start on the last-beat handshake
        push_stage(0, 1'b0);
        start = 1'b1; stage = 3'd0;
        tick();
        start = 1'b0;
        n = 0;
        while (!tw.tw_last && n < 20) begin
            tick();
            n++;
        end
        check("chain_saw_last", int'(tw.tw_last), 1);
        base = exp_q.size();
        push_stage(1, 1'b0);
        set_lane(base + 0, 1, 126, -25);
        start = 1'b1; stage = 3'd1;
        tick();
        start = 1'b0;
        check("chain_valid", int'(tw.tw_valid), 1);
        check("chain_beat0", int'(tw.tw_beat), 0);
        check("chain_busy", int'(busy), 1);
        drain("chain");

        // illegal stage
        start = 1'b1; stage = 3'd6;
        tick();
        start = 1'b0;
        check("err_pulse", int'(err), 1);
        check("err_valid", int'(tw.tw_valid), 0);
        tick();
        check("err_clear", int'(err), 0);
        check("err_busy", int'(busy), 0);

        // reset during beat 1
        push_stage(0, 1'b0);
        start = 1'b1; stage = 3'd0;
        tick();
        start = 1'b0;
        tick();
        check("prerst_beat1", int'(tw.tw_beat), 1);
        tw.tw_ready = 1'b0;
        rst = 1'b1;
        tick();
        check("mrst_valid", int'(tw.tw_valid), 0);
        check("mrst_busy",  int'(busy), 0);
        check("mrst_beat",  int'(tw.tw_beat), 0);
        check("mrst_last",  int'(tw.tw_last), 0);
        check("mrst_data",  int'(tw.tw_re != '0 || tw.tw_im != '0), 0);
        check("mrst_left",  exp_q.size(), 3);
        exp_q.delete();
        rst = 1'b0;
        tw.tw_ready = 1'b1;
        tick();
        check("mrst_idle", int'(tw.tw_valid), 0);

        // recovery after reset: stage 3 inverse
        push_stage(3, 1'b1);
        start = 1'b1; stage = 3'd3; inverse = 1'b1;
        tick();
        start = 1'b0; inverse = 1'b0;
        drain("s3inv");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
